// File: rtl/writeback_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : writeback_regfile_pkg
// Brief  : Y86-64 icodes, register IDs and status encodings for write-back.
// Rev    : 1.0
// ============================================================================
package writeback_regfile_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;
    localparam int         NREGS   = 15;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_e;

    // Address faults outrank illegal encodings, which outrank halt.
    function automatic stat_e inst_status(
        input logic       imem_err,
        input logic       dmem_err,
        input logic       instr_valid,
        input logic [3:0] icode
    );
        if (imem_err || dmem_err)
            return SADR;
        else if (!instr_valid)
            return SINS;
        else if (icode == IHALT)
            return SHLT;
        else
            return SAOK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_regfile_regfile.sv
`default_nettype none
// ============================================================================
// Module : writeback_regfile_regfile
// Brief  : 15 x XLEN register array, two write ports (M wins), two read ports.
// Rev    : 1.0
// ============================================================================
module writeback_regfile_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we_e,
    input  logic [3:0]      i_dst_e,
    input  logic [XLEN-1:0] i_wdata_e,
    input  logic            i_we_m,
    input  logic [3:0]      i_dst_m,
    input  logic [XLEN-1:0] i_wdata_m,
    input  logic [3:0]      i_src_a,
    input  logic [3:0]      i_src_b,
    output logic [XLEN-1:0] o_val_a,
    output logic [XLEN-1:0] o_val_b
);

    logic [XLEN-1:0] r_regs [0:NREGS-1];

    logic w_we_e;
    logic w_we_m;

    assign w_we_e = i_we_e && (i_dst_e != RNONE);
    assign w_we_m = i_we_m && (i_dst_m != RNONE);

    // The M write is issued last so it wins when both target one register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else begin
            if (w_we_e)
                r_regs[i_dst_e] <= i_wdata_e;
            if (w_we_m)
                r_regs[i_dst_m] <= i_wdata_m;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [3:0] src);
        if (src == RNONE)
            return '0;
        else if (BYPASS && w_we_m && (i_dst_m == src))
            return i_wdata_m;
        else if (BYPASS && w_we_e && (i_dst_e == src))
            return i_wdata_e;
        else
            return r_regs[src];
    endfunction

    always_comb begin
        o_val_a = read_port(i_src_a);
        o_val_b = read_port(i_src_b);
    end

endmodule
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module : writeback_regfile
// Brief  : Y86-64 write-back stage: commit gating, sticky status, retire count.
// Rev    : 1.0
// ============================================================================
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       icode_i,
    input  logic             cnd_i,
    input  logic [3:0]       dstE_i,
    input  logic [3:0]       dstM_i,
    input  logic [XLEN-1:0]  valE_i,
    input  logic [XLEN-1:0]  valM_i,
    input  logic             imem_error_i,
    input  logic             instr_valid_i,
    input  logic             dmem_error_i,
    input  logic [3:0]       srcA_i,
    input  logic [3:0]       srcB_i,
    output logic [XLEN-1:0]  valA_o,
    output logic [XLEN-1:0]  valB_o,
    output logic [2:0]       stat_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_o
);

    stat_e            r_stat;
    logic             r_halted;
    logic [CNT_W-1:0] r_retired;

    stat_e w_inst_stat;
    logic  w_active;
    logic  w_commit;
    logic  w_we_e;
    logic  w_we_m;

    assign w_inst_stat = inst_status(imem_error_i, dmem_error_i, instr_valid_i, icode_i);
    assign w_active    = valid_i && (r_stat == SAOK) && !rst_i;
    assign w_commit    = w_active && (w_inst_stat == SAOK);

    // A not-taken cmovXX is still retired but must leave its destination alone.
    assign w_we_e = w_commit && (dstE_i != RNONE) && !((icode_i == IRRMOVQ) && !cnd_i);
    assign w_we_m = w_commit && (dstM_i != RNONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat    <= SAOK;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else begin
            case (r_stat)
                SAOK: begin
                    if (w_commit) begin
                        r_retired <= r_retired + CNT_W'(1);
                    end else if (w_active) begin
                        r_stat   <= w_inst_stat;
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_stat   <= r_stat;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    writeback_regfile_regfile #(
        .XLEN   (XLEN),
        .BYPASS (BYPASS)
    ) u_regfile (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_we_e    (w_we_e),
        .i_dst_e   (dstE_i),
        .i_wdata_e (valE_i),
        .i_we_m    (w_we_m),
        .i_dst_m   (dstM_i),
        .i_wdata_m (valM_i),
        .i_src_a   (srcA_i),
        .i_src_b   (srcB_i),
        .o_val_a   (valA_o),
        .o_val_b   (valB_o)
    );

    assign stat_o    = r_stat;
    assign halted_o  = r_halted;
    assign retired_o = r_retired;

endmodule
`default_nettype wire
